mips_vector_checker: RTL and testbench
======================================

Name: mips_vector_checker

Overview:
- Parametrised, synthesizable self-checking engine for processor bring-up.
- Holds a preloaded expected-vector memory and drives per-vector stimulus bits.
- Compares sampled DUT observation buses against the expected values under per-vector don't-care masks.
- Keeps saturating error and first-failure records; used by the processor benches and on-chip debug wrappers.

Parameters:
DATA_W, 192, width of data observation bus (addr, writedata, pc, wrData, A, B)
CTRL_W, 18, width of control observation bus (memread, memwrite, regwrite, register addresses)
STIM_W, 1, stimulus bits stored per vector (bit 0 = processor reset)
DEPTH, 128, vector memory entries
IDX_W, $clog2(DEPTH), vector index width
ERR_W, 16, error counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
ld_en  in  1  vector memory write strobe
ld_idx  in  IDX_W  write index
ld_data  in  DATA_W  expected data
ld_ctrl  in  CTRL_W  expected control
ld_mask  in  DATA_W+CTRL_W  compare-enable mask, 1 = compare bit ({data,ctrl} order)
ld_stim  in  STIM_W  stimulus for that vector
num_vec  in  IDX_W  last vector index to run (run covers 0..num_vec inclusive)
start  in  1  begin run
sample  in  1  DUT outputs valid for current vector
act_data  in  DATA_W  observed data
act_ctrl  in  CTRL_W  observed control
stim  out  STIM_W  stimulus of current vector
exp_data  out  DATA_W  current expected data
exp_ctrl  out  CTRL_W  current expected control
vectornum  out  IDX_W  current vector index
errors  out  ERR_W  mismatch count, saturating
mismatch  out  1  one-cycle pulse after a failing sample
first_fail_vld  out  1  a failure has been recorded this run
first_fail_idx  out  IDX_W  index of first failing vector
busy  out  1  state == RUN
done  out  1  state == DONE

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; memory contents not reset.
- FSM IDLE -> RUN on start.
- FSM RUN -> DONE on sample while vectornum == num_vec.
- FSM DONE -> RUN on start (restart); DONE otherwise holds.
- Start edge: vectornum=0; errors=0; first_fail_vld=0; exp_*, stim and internal mask registered from mem[0].
- Expected outputs are valid from the cycle after start; no bubbles.
- Sample in RUN (one vector per sample, any cadence, back-to-back allowed):
  - Fail = |((({act_data,act_ctrl}) ^ ({exp_data,exp_ctrl})) & mask).
  - On fail: errors increments unless all-ones (saturate); mismatch=1 the next cycle.
  - On fail with first_fail_vld==0: capture vectornum and set first_fail_vld.
  - If vectornum != num_vec: vectornum+1; exp/stim/mask reload from mem[vectornum+1] on the same edge.
- Sample in IDLE or DONE is ignored. Start during RUN is ignored.
- ld_en is honoured only in IDLE/DONE; ignored in RUN. ld_idx >= DEPTH is ignored.
- Simultaneous start and ld_en in IDLE: write occurs. If ld_idx==0, the new entry is what start loads (write-first bypass).
- num_vec >= DEPTH is clamped to DEPTH-1 at start.
- In DONE: errors, first_fail_*, exp_* and vectornum hold their final values.
- Reset asserted mid-run: immediate return to IDLE, counters cleared.
- Mask all zero for a vector: always passes.

Decomposition:
- Package mips_tb_pkg holds:
  - typedefs chk_state_t {IDLE, RUN, DONE};
  - field-offset constants for the data and control buses (ADDR_LSB, PC_LSB, WRADDR_LSB, ...);
  - a default mask constant.
- One sub-module, mips_vector_mem: DEPTH x (STIM_W+DATA_W+CTRL_W+mask) register array with one write port and registered read with write-first bypass.

Test Plan:
- Reset low mid-load, release -> all outputs 0, busy=0, done=0; earlier loaded entries still readable via start.
- Load 3 vectors, num_vec=2, start, 3 matching samples -> vectornum 0,1,2; done=1 the cycle after the third sample; errors=0.
- Vector 1 act_data differs in bit 5 (mask bit 5 = 1) -> mismatch pulse 1 cycle, errors=1, first_fail_idx=1. A second fail at vector 2 -> errors=2, first_fail_idx stays 1.
- Same bit-5 difference with mask bit 5 = 0 -> no mismatch, errors=0.
- ERR_W=2, 5 failing vectors -> errors sticks at 3.
- start or ld_en during RUN -> ignored, memory unchanged. Sample in DONE -> no change. Start from DONE -> counters cleared; stim shows mem[0] stimulus (1 for reset vector).

Source files
------------

// File: rtl/mips_vector_checker_pkg.sv
// mips_tb_pkg: shared types and constants for the MIPS vector checker.
//   chk_state_t   : checker FSM state (IDLE / RUN / DONE)
//   *_LSB / *_BIT : field positions inside the data and control observation buses
//   DEFAULT_MASK  : compare every bit of {data, ctrl}
package mips_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  // Default bus geometry used by the processor benches.
  localparam int unsigned DEF_DATA_W = 192;
  localparam int unsigned DEF_CTRL_W = 18;
  localparam int unsigned FIELD_W    = 32;
  localparam int unsigned REGADDR_W  = 5;

  // Data bus: {addr, writedata, pc, wrData, A, B}, 32 bits each, addr at the top.
  localparam int unsigned ADDR_LSB   = 160;
  localparam int unsigned WDATA_LSB  = 128;
  localparam int unsigned PC_LSB     = 96;
  localparam int unsigned WRDATA_LSB = 64;
  localparam int unsigned A_LSB      = 32;
  localparam int unsigned B_LSB      = 0;

  // Control bus: {memread, memwrite, regwrite, rs, rt, wraddr}.
  localparam int unsigned MEMREAD_BIT  = 17;
  localparam int unsigned MEMWRITE_BIT = 16;
  localparam int unsigned REGWRITE_BIT = 15;
  localparam int unsigned RS_LSB       = 10;
  localparam int unsigned RT_LSB       = 5;
  localparam int unsigned WRADDR_LSB   = 0;

  localparam logic [DEF_DATA_W+DEF_CTRL_W-1:0] DEFAULT_MASK = '1;

endpackage

// File: rtl/mips_vector_checker_if.sv
// mips_vector_checker_if: load / run / observe bus of the vector checker.
//   master : drives vector loads, run control and the sampled DUT observations
//   slave  : the checker; returns stimulus, expected values and error records
interface mips_vector_checker_if
  import mips_tb_pkg::*;
#(
  parameter int unsigned DATA_W = 192,
  parameter int unsigned CTRL_W = 18,
  parameter int unsigned STIM_W = 1,
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned ERR_W  = 16
);
  logic                     ld_en;
  logic [IDX_W-1:0]         ld_idx;
  logic [DATA_W-1:0]        ld_data;
  logic [CTRL_W-1:0]        ld_ctrl;
  logic [DATA_W+CTRL_W-1:0] ld_mask;
  logic [STIM_W-1:0]        ld_stim;
  logic [IDX_W-1:0]         num_vec;
  logic                     start;
  logic                     sample;
  logic [DATA_W-1:0]        act_data;
  logic [CTRL_W-1:0]        act_ctrl;

  logic [STIM_W-1:0]        stim;
  logic [DATA_W-1:0]        exp_data;
  logic [CTRL_W-1:0]        exp_ctrl;
  logic [IDX_W-1:0]         vectornum;
  logic [ERR_W-1:0]         errors;
  logic                     mismatch;
  logic                     first_fail_vld;
  logic [IDX_W-1:0]         first_fail_idx;
  logic                     busy;
  logic                     done;

  modport master (
    output ld_en, ld_idx, ld_data, ld_ctrl, ld_mask, ld_stim, num_vec, start, sample,
           act_data, act_ctrl,
    input  stim, exp_data, exp_ctrl, vectornum, errors, mismatch, first_fail_vld,
           first_fail_idx, busy, done
  );

  modport slave (
    input  ld_en, ld_idx, ld_data, ld_ctrl, ld_mask, ld_stim, num_vec, start, sample,
           act_data, act_ctrl,
    output stim, exp_data, exp_ctrl, vectornum, errors, mismatch, first_fail_vld,
           first_fail_idx, busy, done
  );
endinterface

// File: rtl/mips_vector_checker_mem.sv
// mips_vector_mem: DEPTH x WORD_W vector store, one write port, registered read.
//   clk          : clock
//   we/widx/wdata: write port
//   re/ridx      : read request, data appears on rdata the next cycle
//   rdata        : read register; holds its value while re is low
// A read and write to the same index on the same edge returns the new word.
module mips_vector_mem
  import mips_tb_pkg::*;
#(
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned WORD_W = 421
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [IDX_W-1:0]  ridx,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= wdata;
    if (re) rdata_q <= (we && (widx == ridx)) ? wdata : mem_q[ridx];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/mips_vector_checker.sv
// mips_vector_checker: replays preloaded expected vectors and compares sampled
// DUT observations against them under per-vector masks.
//   clk   : clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of mips_vector_checker_if (loads, run control,
//           observations in; stimulus, expected values, error records out)
module mips_vector_checker
  import mips_tb_pkg::*;
#(
  parameter int unsigned DATA_W = 192,
  parameter int unsigned CTRL_W = 18,
  parameter int unsigned STIM_W = 1,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned IDX_W  = $clog2(DEPTH),
  parameter int unsigned ERR_W  = 16
) (
  input logic                  clk,
  input logic                  reset,
  mips_vector_checker_if.slave bus
);
  localparam int unsigned CMP_W     = DATA_W + CTRL_W;
  localparam int unsigned WORD_W    = STIM_W + CMP_W + CMP_W;
  // Stored word layout: {stim, data, ctrl, mask}
  localparam int unsigned CTRL_LSB  = CMP_W;
  localparam int unsigned DATA_LSB  = CMP_W + CTRL_W;
  localparam int unsigned STIM_LSB  = CMP_W + CMP_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  chk_state_t       state_q;
  logic [IDX_W-1:0] vectornum_q, last_q, ff_idx_q;
  logic [ERR_W-1:0] errors_q, errors_d;
  logic             mismatch_q, ff_vld_q, rd_valid_q;

  logic              ld_idx_ok, in_run, start_fire, sample_fire, at_last, fail;
  logic              mem_we, mem_re;
  logic [IDX_W-1:0]  mem_ridx, num_vec_clamped;
  logic [WORD_W-1:0] rd_word;
  logic [STIM_W-1:0] rd_stim;
  logic [DATA_W-1:0] rd_data;
  logic [CTRL_W-1:0] rd_ctrl;
  logic [CMP_W-1:0]  rd_mask;

  // Range checks only exist when the index can encode values past the array.
  generate
    if ((2 ** IDX_W) > DEPTH) begin : g_partial_range
      assign ld_idx_ok       = (32'(bus.ld_idx) < DEPTH);
      assign num_vec_clamped = (32'(bus.num_vec) > (DEPTH - 1)) ? LAST_IDX : bus.num_vec;
    end else begin : g_full_range
      assign ld_idx_ok       = 1'b1;
      assign num_vec_clamped = bus.num_vec;
    end
  endgenerate

  assign in_run      = (state_q == RUN);
  assign start_fire  = bus.start && !in_run;
  assign sample_fire = bus.sample && in_run;
  assign at_last     = (vectornum_q == last_q);

  // Loads are locked out while a run is replaying the memory.
  assign mem_we   = bus.ld_en && !in_run && ld_idx_ok;
  // Prefetch the next vector on the sampling edge so expected values never bubble.
  assign mem_re   = start_fire || (sample_fire && !at_last);
  assign mem_ridx = start_fire ? '0 : vectornum_q + IDX_W'(1);

  mips_vector_mem #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .WORD_W (WORD_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .widx  (bus.ld_idx),
    .wdata ({bus.ld_stim, bus.ld_data, bus.ld_ctrl, bus.ld_mask}),
    .re    (mem_re),
    .ridx  (mem_ridx),
    .rdata (rd_word)
  );

  assign rd_stim = rd_word[STIM_LSB +: STIM_W];
  assign rd_data = rd_word[DATA_LSB +: DATA_W];
  assign rd_ctrl = rd_word[CTRL_LSB +: CTRL_W];
  assign rd_mask = rd_word[CMP_W-1:0];

  assign fail     = |(({bus.act_data, bus.act_ctrl} ^ {rd_data, rd_ctrl}) & rd_mask);
  assign errors_d = (errors_q == {ERR_W{1'b1}}) ? errors_q : errors_q + ERR_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      vectornum_q <= '0;
      last_q      <= '0;
      errors_q    <= '0;
      mismatch_q  <= 1'b0;
      ff_vld_q    <= 1'b0;
      ff_idx_q    <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      mismatch_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q     <= RUN;
            vectornum_q <= '0;
            last_q      <= num_vec_clamped;
            errors_q    <= '0;
            ff_vld_q    <= 1'b0;
            ff_idx_q    <= '0;
            rd_valid_q  <= 1'b1;
          end
        end
        RUN: begin
          if (bus.sample) begin
            if (fail) begin
              errors_q   <= errors_d;
              mismatch_q <= 1'b1;
              if (!ff_vld_q) begin
                ff_vld_q <= 1'b1;
                ff_idx_q <= vectornum_q;
              end
            end
            if (at_last) state_q <= DONE;
            else         vectornum_q <= vectornum_q + IDX_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The read register is not reset, so expected values are held at zero until a run loads them.
  assign bus.stim           = rd_valid_q ? rd_stim : '0;
  assign bus.exp_data       = rd_valid_q ? rd_data : '0;
  assign bus.exp_ctrl       = rd_valid_q ? rd_ctrl : '0;
  assign bus.vectornum      = vectornum_q;
  assign bus.errors         = errors_q;
  assign bus.mismatch       = mismatch_q;
  assign bus.first_fail_vld = ff_vld_q;
  assign bus.first_fail_idx = ff_idx_q;
  assign bus.busy           = (state_q == RUN);
  assign bus.done           = (state_q == DONE);
endmodule

// File: tb/tb_mips_vector_checker.sv
`timescale 1ns/1ps
module tb_mips_vector_checker;
  import mips_tb_pkg::*;

  localparam int DW = 192, CW = 18, SW = 1, DEP = 128, IW = 7, EW = 16;
  localparam int CMPW = DW + CW;
  localparam int SDEP = 6, SIW = 3, SEW = 2;
  localparam int ERRMAX = (1 << EW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_vector_checker_if #(.DATA_W(DW), .CTRL_W(CW), .STIM_W(SW), .IDX_W(IW), .ERR_W(EW)) bus();
  mips_vector_checker_if #(.DATA_W(DW), .CTRL_W(CW), .STIM_W(SW), .IDX_W(SIW), .ERR_W(SEW)) sbus();

  mips_vector_checker #(.DATA_W(DW), .CTRL_W(CW), .STIM_W(SW), .DEPTH(DEP), .IDX_W(IW), .ERR_W(EW))
    dut (.clk(clk), .reset(reset), .bus(bus.slave));
  mips_vector_checker #(.DATA_W(DW), .CTRL_W(CW), .STIM_W(SW), .DEPTH(SDEP), .IDX_W(SIW), .ERR_W(SEW))
    dut_s (.clk(clk), .reset(reset), .bus(sbus.slave));

  int total = 0;
  int bad = 0;

  // Reference model: vector contents plus run-level bookkeeping.
  logic [DW-1:0]   m_data [DEP];
  logic [CW-1:0]   m_ctrl [DEP];
  logic [CMPW-1:0] m_mask [DEP];
  logic [SW-1:0]   m_stim [DEP];
  int mv, mlast, merr, mffi;
  logic mffv, mdone;

  typedef struct {
    logic [2:0] flip;    // vectors whose act_data bit 5 is corrupted
    logic       mask5;   // compare enable for data bit 5
    int         exp_err;
    logic       exp_ffv;
    int         exp_ffi;
  } row_t;
  row_t rows [5];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic load(input int idx, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic [CMPW-1:0] m, input logic [SW-1:0] s);
    bus.ld_en = 1'b1; bus.ld_idx = IW'(idx);
    bus.ld_data = d; bus.ld_ctrl = c; bus.ld_mask = m; bus.ld_stim = s;
    m_data[idx] = d; m_ctrl[idx] = c; m_mask[idx] = m; m_stim[idx] = s;
    tick();
    bus.ld_en = 1'b0;
  endtask

  task automatic run_start(input int num);
    bus.num_vec = IW'(num); bus.start = 1'b1;
    tick();
    bus.start = 1'b0; bus.ld_en = 1'b0;
    mv = 0; mlast = (num > DEP - 1) ? DEP - 1 : num;
    merr = 0; mffv = 1'b0; mffi = 0; mdone = 1'b0;
    chk("start_busy", bus.busy, 1'b1);
    chk("start_done", bus.done, 1'b0);
    chk("start_vectornum", bus.vectornum, 0);
    chk("start_errors", bus.errors, 0);
    chk("start_ffvld", bus.first_fail_vld, 1'b0);
    chk("start_exp_data", bus.exp_data, m_data[0]);
    chk("start_stim", bus.stim, m_stim[0]);
  endtask

  task automatic do_sample(input logic [DW-1:0] ad, input logic [CW-1:0] ac);
    logic [CMPW-1:0] diff;
    logic f;
    chk("pre_exp_data", bus.exp_data, m_data[mv]);
    chk("pre_exp_ctrl", bus.exp_ctrl, m_ctrl[mv]);
    chk("pre_stim", bus.stim, m_stim[mv]);
    chk("pre_vectornum", bus.vectornum, mv);
    bus.act_data = ad; bus.act_ctrl = ac; bus.sample = 1'b1;
    tick();
    bus.sample = 1'b0;
    diff = ({ad, ac} ^ {m_data[mv], m_ctrl[mv]}) & m_mask[mv];
    f = (diff != '0);
    if (f) begin
      if (merr < ERRMAX) merr++;
      if (!mffv) begin mffv = 1'b1; mffi = mv; end
    end
    $display("txn vec=%0d miscompare=%0b errors=%0d", mv, f, merr);
    if (mv == mlast) mdone = 1'b1; else mv++;
    chk("smp_mismatch", bus.mismatch, f);
    chk("smp_errors", bus.errors, merr);
    chk("smp_ffvld", bus.first_fail_vld, mffv);
    if (mffv) chk("smp_ffidx", bus.first_fail_idx, mffi);
    chk("smp_done", bus.done, mdone);
    chk("smp_busy", bus.busy, !mdone);
    chk("smp_vectornum", bus.vectornum, mv);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stim"}, bus.stim, 0);
    chk({tag, "_exp_data"}, bus.exp_data, 0);
    chk({tag, "_exp_ctrl"}, bus.exp_ctrl, 0);
    chk({tag, "_vectornum"}, bus.vectornum, 0);
    chk({tag, "_errors"}, bus.errors, 0);
    chk({tag, "_mismatch"}, bus.mismatch, 0);
    chk({tag, "_ffvld"}, bus.first_fail_vld, 0);
    chk({tag, "_ffidx"}, bus.first_fail_idx, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CMPW-1:0] msk;
    logic [DW-1:0]   fl;
    int n, sel, b;

    bus.ld_en = 0; bus.ld_idx = '0; bus.ld_data = '0; bus.ld_ctrl = '0; bus.ld_mask = '0;
    bus.ld_stim = '0; bus.num_vec = '0; bus.start = 0; bus.sample = 0;
    bus.act_data = '0; bus.act_ctrl = '0;
    sbus.ld_en = 0; sbus.ld_idx = '0; sbus.ld_data = '0; sbus.ld_ctrl = '0; sbus.ld_mask = '0;
    sbus.ld_stim = '0; sbus.num_vec = '0; sbus.start = 0; sbus.sample = 0;
    sbus.act_data = '0; sbus.act_ctrl = '0;

    rows[0] = '{flip: 3'b000, mask5: 1'b1, exp_err: 0, exp_ffv: 1'b0, exp_ffi: 0};
    rows[1] = '{flip: 3'b010, mask5: 1'b1, exp_err: 1, exp_ffv: 1'b1, exp_ffi: 1};
    rows[2] = '{flip: 3'b110, mask5: 1'b1, exp_err: 2, exp_ffv: 1'b1, exp_ffi: 1};
    rows[3] = '{flip: 3'b010, mask5: 1'b0, exp_err: 0, exp_ffv: 1'b0, exp_ffi: 0};
    rows[4] = '{flip: 3'b101, mask5: 1'b1, exp_err: 2, exp_ffv: 1'b1, exp_ffi: 0};

    // Power-on reset.
    #2 reset = 1'b0;
    tick(); tick();
    chk_all_zero("por");
    reset = 1'b1;

    // Load, reset in the middle of loading, memory must survive.
    load(0, rnd_data(), CW'($urandom), DEFAULT_MASK, 1'b1);
    load(1, rnd_data(), CW'($urandom), DEFAULT_MASK, 1'b0);
    reset = 1'b0;
    tick(); tick();
    chk_all_zero("midload");
    reset = 1'b1;
    load(2, rnd_data(), CW'($urandom), DEFAULT_MASK, 1'b0);
    run_start(1);
    do_sample(m_data[0], m_ctrl[0]);
    do_sample(m_data[1] ^ 192'h100, m_ctrl[1]);

    // Asynchronous reset in the middle of a run.
    run_start(2);
    do_sample(m_data[0] ^ 192'h1, m_ctrl[0]);
    chk("pre_rst_errors", bus.errors, 1);
    reset = 1'b0;
    #1;
    chk("async_busy", bus.busy, 0);
    chk("async_errors", bus.errors, 0);
    chk("async_vectornum", bus.vectornum, 0);
    chk("async_ffvld", bus.first_fail_vld, 0);
    chk("async_exp_data", bus.exp_data, 0);
    tick();
    reset = 1'b1;

    // Table of three-vector runs probing bit 5 under its mask bit.
    for (int r = 0; r < 5; r++) begin
      msk = DEFAULT_MASK;
      msk[CW + 5] = rows[r].mask5;
      for (int k = 0; k < 3; k++)
        load(k, {6{32'h1111_0000 + 32'(k * 16 + r)}}, CW'(k * 3 + 1), msk, SW'(k == 0));
      run_start(2);
      for (int k = 0; k < 3; k++) begin
        fl = '0;
        fl[5] = rows[r].flip[k];
        do_sample(m_data[k] ^ fl, m_ctrl[k]);
        tick();
        chk("tbl_pulse_end", bus.mismatch, 0);
      end
      chk("tbl_errors", bus.errors, rows[r].exp_err);
      chk("tbl_ffvld", bus.first_fail_vld, rows[r].exp_ffv);
      if (rows[r].exp_ffv) chk("tbl_ffidx", bus.first_fail_idx, rows[r].exp_ffi);
      chk("tbl_done", bus.done, 1);
    end

    // Start and loads during RUN are ignored; sample in DONE is ignored.
    for (int k = 0; k < 3; k++) load(k, rnd_data(), CW'($urandom), DEFAULT_MASK, SW'(k == 0));
    run_start(2);
    do_sample(m_data[0], m_ctrl[0]);
    bus.ld_en = 1'b1; bus.ld_idx = IW'(2); bus.ld_data = ~m_data[2]; bus.ld_ctrl = ~m_ctrl[2];
    bus.ld_mask = '0; bus.start = 1'b1;
    tick();
    bus.ld_en = 1'b0; bus.start = 1'b0;
    chk("run_ign_vectornum", bus.vectornum, 1);
    chk("run_ign_busy", bus.busy, 1);
    do_sample(m_data[1] ^ 192'h8, m_ctrl[1]);
    do_sample(m_data[2] ^ 192'h4, m_ctrl[2]);
    bus.act_data = ~m_data[2]; bus.sample = 1'b1;
    tick();
    bus.sample = 1'b0;
    chk("done_smp_errors", bus.errors, 2);
    chk("done_smp_mismatch", bus.mismatch, 0);
    chk("done_smp_vectornum", bus.vectornum, 2);
    chk("done_smp_done", bus.done, 1);
    chk("done_smp_exp", bus.exp_data, m_data[2]);
    chk("done_smp_ffidx", bus.first_fail_idx, 1);

    // Restart from DONE with a simultaneous write to entry 0 (write-first).
    bus.ld_en = 1'b1; bus.ld_idx = '0; bus.ld_data = rnd_data(); bus.ld_ctrl = CW'($urandom);
    bus.ld_mask = DEFAULT_MASK; bus.ld_stim = 1'b1;
    m_data[0] = bus.ld_data; m_ctrl[0] = bus.ld_ctrl; m_mask[0] = DEFAULT_MASK; m_stim[0] = 1'b1;
    run_start(2);
    for (int k = 0; k < 3; k++) do_sample(m_data[k], m_ctrl[k]);

    // Randomized runs against the model.
    for (int run = 0; run < 8; run++) begin
      n = $urandom_range(1, 16);
      for (int k = 0; k < n; k++) begin
        sel = $urandom_range(0, 3);
        if (sel == 0) msk = '0;
        else if (sel == 1) msk = DEFAULT_MASK;
        else msk = {rnd_data(), CW'($urandom)} & {rnd_data(), CW'($urandom)};
        load(k, rnd_data(), CW'($urandom), msk, SW'($urandom_range(0, 1)));
      end
      run_start(n - 1);
      for (int k = 0; k < n; k++) begin
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        sel = $urandom_range(0, 3);
        fl = '0;
        if (sel == 2) begin b = $urandom_range(0, DW - 1); fl[b] = 1'b1; end
        else if (sel == 3) fl = rnd_data();
        do_sample(m_data[k] ^ fl, m_ctrl[k] ^ ((sel == 3) ? CW'($urandom) : CW'(0)));
      end
    end

    // Narrow counter and clamped num_vec on the small instance.
    for (int k = 0; k < SDEP; k++) begin
      sbus.ld_en = 1'b1; sbus.ld_idx = SIW'(k); sbus.ld_data = '0; sbus.ld_ctrl = '0;
      sbus.ld_mask = DEFAULT_MASK; sbus.ld_stim = SW'(k == 0);
      tick();
    end
    sbus.ld_en = 1'b0;
    sbus.num_vec = SIW'(7); sbus.start = 1'b1;
    tick();
    sbus.start = 1'b0;
    chk("s_busy", sbus.busy, 1);
    chk("s_stim", sbus.stim, 1);
    for (int k = 0; k < SDEP; k++) begin
      sbus.act_data = '1; sbus.act_ctrl = '0; sbus.sample = 1'b1;
      tick();
      sbus.sample = 1'b0;
      $display("txn small vec=%0d errors=%0d", k, sbus.errors);
      chk("s_errors", sbus.errors, (k + 1 > 3) ? 3 : k + 1);
      chk("s_mismatch", sbus.mismatch, 1);
      chk("s_done", sbus.done, k == SDEP - 1);
    end
    chk("s_vectornum", sbus.vectornum, SDEP - 1);
    chk("s_ffidx", sbus.first_fail_idx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
